sprite_line_renderer: RTL and testbench

Per-scanline sprite renderer that sits directly downstream of the horizontal/vertical sync generator. It consumes `hpos`, `vpos` and `display_on`. During each horizontal blank it fetches one row of a fixed-size 1-bit sprite from an external synchronous ROM. On the following scanline it shifts that row out as a pixel stream. Its `pixel` output is registered so it lines up with the generator's registered `hsync`/`vsync` and feeds the colour mixer.

---
 rtl/video_timing_pkg.sv | 25 ++
 rtl/sprite_row_shifter.sv | 42 ++++
 rtl/sprite_line_renderer.sv | 102 ++++++++++
 tb/tb_sprite_line_renderer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared raster timing constants and renderer state type
// Contents:
//   H_DISPLAY/H_TOTAL/V_DISPLAY/V_TOTAL  raster geometry shared with the sync generator
//   render_state_t                       sprite renderer FSM encoding
//   next_line_of()                       scanline that follows a given vpos, wrapping at V_TOTAL
package video_timing_pkg;

    localparam int H_DISPLAY = 256;
    localparam int H_TOTAL   = 309;
    localparam int V_DISPLAY = 240;
    localparam int V_TOTAL   = 262;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_WAIT_X,
        ST_DRAW
    } render_state_t;

    function automatic logic [8:0] next_line_of(input logic [8:0] v);
        return (v == 9'(V_TOTAL - 1)) ? 9'd0 : v + 9'd1;
    endfunction

endpackage

// File: rtl/sprite_row_shifter.sv
// rtl/sprite_row_shifter.sv - sprite row load/shift register with emitted-pixel counter
// Ports:
//   clk, reset        pixel clock, asynchronous active-low reset
//   load, load_data   parallel load of one sprite row; clears the counter
//   shift             emit current MSB, shift left, count the pixel
//   msb               leftmost pixel still pending
//   done              high while the pixel being emitted is the last of the row
module sprite_row_shifter #(
    parameter int SPR_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [SPR_W-1:0] load_data,
    input  logic             shift,
    output logic             msb,
    output logic             done
);

    localparam int CW = $clog2(SPR_W + 1);

    logic [SPR_W-1:0] shreg;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= load_data;
            cnt   <= '0;
        end else if (shift) begin
            shreg <= {shreg[SPR_W-2:0], 1'b0};
            cnt   <= cnt + CW'(1);
        end
    end

    assign msb  = shreg[SPR_W-1];
    // cnt counts pixels already emitted, so this flags the final emission
    assign done = (cnt == CW'(SPR_W - 1));

endmodule

// File: rtl/sprite_line_renderer.sv
// rtl/sprite_line_renderer.sv - fetches one sprite row per hblank and draws it on the next line
// Ports:
//   clk, reset                    pixel clock, asynchronous active-low reset
//   hpos, vpos, display_on        raster position from the sync generator
//   sprite_x, sprite_y            sprite origin, sampled at the fetch point
//   rom_addr, rom_data            synchronous sprite ROM, one-cycle read latency
//   pixel                         registered sprite pixel for the previous column
//   active                        a row is being fetched, pending or drawn
module sprite_line_renderer
    import video_timing_pkg::*;
#(
    parameter int SPR_W  = 16,
    parameter int SPR_H  = 16,
    parameter int ROW_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        hpos,
    input  logic [8:0]        vpos,
    input  logic              display_on,
    input  logic [8:0]        sprite_x,
    input  logic [8:0]        sprite_y,
    output logic [ROW_AW-1:0] rom_addr,
    input  logic [SPR_W-1:0]  rom_data,
    output logic              pixel,
    output logic              active
);

    render_state_t     state;
    logic [ROW_AW-1:0] row_r;
    logic [8:0]        x_r;

    logic       fetch_pt;
    logic [8:0] row;
    logic       row_hit;
    logic       emit;
    logic       msb;
    logic       done;

    // Row arithmetic wraps mod 512, so rows above the sprite top land far above SPR_H
    // and a sprite near the bottom never reappears on line 0.
    assign fetch_pt = (hpos == 9'(H_DISPLAY));
    assign row      = next_line_of(vpos) - sprite_y;
    assign row_hit  = (row < 9'(SPR_H));

    // The WAIT_X match cycle already emits the first (leftmost) pixel.
    assign emit     = (state == ST_DRAW) || ((state == ST_WAIT_X) && (hpos == x_r));

    // row_r only changes at a fetch, so it doubles as the held ROM address.
    assign rom_addr = row_r;

    sprite_row_shifter #(.SPR_W(SPR_W)) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (state == ST_LATCH),
        .load_data (rom_data),
        .shift     (emit),
        .msb       (msb),
        .done      (done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            pixel  <= 1'b0;
            active <= 1'b0;
            row_r  <= '0;
            x_r    <= '0;
        end else begin
            pixel <= emit & msb & display_on;
            if (fetch_pt) begin
                // Fetch point overrides any draw still in progress.
                if (row_hit) begin
                    row_r  <= row[ROW_AW-1:0];
                    x_r    <= sprite_x;
                    state  <= ST_FETCH;
                    active <= 1'b1;
                end else begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end
            end else begin
                case (state)
                    ST_FETCH:  state <= ST_LATCH;
                    ST_LATCH:  state <= ST_WAIT_X;
                    ST_WAIT_X: if (hpos == x_r) state <= ST_DRAW;
                    ST_DRAW: begin
                        if (done) begin
                            state  <= ST_IDLE;
                            active <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb/tb_sprite_line_renderer.sv - directed scoreboard bench for sprite_line_renderer
module tb_sprite_line_renderer;
    import video_timing_pkg::*;

    localparam int SPR_W  = 16;
    localparam int SPR_H  = 16;
    localparam int ROW_AW = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [8:0]        hpos = '0;
    logic [8:0]        vpos = '0;
    logic              display_on = 1'b0;
    logic [8:0]        sprite_x = '0;
    logic [8:0]        sprite_y = '0;
    logic [ROW_AW-1:0] rom_addr;
    logic [SPR_W-1:0]  rom_data;
    logic              pixel;
    logic              active;

    logic [SPR_W-1:0]  rom [SPR_H];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    sprite_line_renderer #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ROW_AW(ROW_AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pixel      (pixel),
        .active     (active)
    );

    typedef struct {
        logic px;
        int   v;
        int   h;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cur_v = 0;
    int cur_h = 0;

    bit pend_valid = 0;
    int pend_line = 0;
    int pend_row = 0;
    int pend_x = 0;

    bit line_seen [V_TOTAL];
    int ones_line [V_TOTAL];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s v=%0d h=%0d observed=%h expected=%h", tag, cur_v, cur_h, obs, expv);
        end
    endtask

    // Expected pixel for raster position (v,h) from the row fetched on the previous line.
    function automatic logic model_px(input int v, input int h);
        int off;
        if (!pend_valid || pend_line != v || v >= V_DISPLAY || h >= H_DISPLAY) return 1'b0;
        off = h - pend_x;
        if (off < 0 || off >= SPR_W) return 1'b0;
        return rom[pend_row][SPR_W-1-off];
    endfunction

    task automatic tick();
        exp_t e;
        bit   fetch_exp;
        int   nl;
        int   row;
        logic [15:0] exp_addr;
        fetch_exp = 0;
        exp_addr  = '0;
        hpos       = cur_h[8:0];
        vpos       = cur_v[8:0];
        display_on = (cur_h < H_DISPLAY) && (cur_v < V_DISPLAY);
        if (!reset) pend_valid = 0;
        e.px = model_px(cur_v, cur_h);
        e.v  = cur_v;
        e.h  = cur_h;
        exp_q.push_back(e);
        if (reset && cur_h == H_DISPLAY) begin
            nl  = (cur_v == V_TOTAL - 1) ? 0 : cur_v + 1;
            row = (nl - int'(sprite_y)) & 511;
            if (row < SPR_H) begin
                pend_valid = 1;
                pend_line  = nl;
                pend_row   = row;
                pend_x     = int'(sprite_x);
                fetch_exp  = 1;
                exp_addr   = 16'(row);
            end else begin
                pend_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pixel", 16'(pixel), 16'(e.px));
        if (pixel === 1'b1) ones_line[cur_v]++;
        if (active === 1'b1) line_seen[cur_v] = 1;
        if (reset && cur_h == H_DISPLAY) begin
            if (fetch_exp) begin
                check("fetch_addr", 16'(rom_addr), exp_addr);
                check("fetch_active", 16'(active), 16'd1);
            end else begin
                check("nofetch_active", 16'(active), 16'd0);
            end
        end
        if (cur_h == H_TOTAL - 1) begin
            cur_h = 0;
            cur_v = (cur_v == V_TOTAL - 1) ? 0 : cur_v + 1;
        end else begin
            cur_h++;
        end
    endtask

    task automatic run(input int v, input int h, input int n);
        cur_v = v;
        cur_h = h;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pend_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < V_TOTAL; i++) begin
            line_seen[i] = 0;
            ones_line[i] = 0;
        end
    endtask

    task automatic load_pattern_rom();
        for (int i = 0; i < SPR_H; i++)
            rom[i] = 16'hFF00 | 16'(i << 4) | 16'((~i) & 15);
    endtask

    initial begin
        for (int i = 0; i < SPR_H; i++) rom[i] = '0;

        // Reset values while reset is held, before any clock edge
        #1;
        check("reset_pixel", 16'(pixel), 16'd0);
        check("reset_active", 16'(active), 16'd0);
        check("reset_rom_addr", 16'(rom_addr), 16'd0);

        // Basic draw: single row 0x8001 at x=100, y=50
        do_reset();
        rom[0]   = 16'h8001;
        sprite_x = 9'd100;
        sprite_y = 9'd50;
        run(49, 250, 59 + H_TOTAL);
        check("basic_ones_l50", 16'(ones_line[50]), 16'd2);

        // Vertical extent: all rows solid, lines 50..65 only
        do_reset();
        for (int i = 0; i < SPR_H; i++) rom[i] = 16'hFFFF;
        run(49, 250, 59 + 17 * H_TOTAL);
        for (int v = 49; v <= 66; v++)
            check($sformatf("extent_ones_l%0d", v), 16'(ones_line[v]),
                  (v >= 50 && v <= 65) ? 16'd16 : 16'd0);

        // Right clip at x=250
        do_reset();
        sprite_x = 9'd250;
        run(49, 250, 59 + H_TOTAL);
        check("clip_ones_l50", 16'(ones_line[50]), 16'd6);

        // Frame wrap: sprite_y=0 fetched on line 261
        do_reset();
        load_pattern_rom();
        sprite_x = 9'd100;
        sprite_y = 9'd0;
        run(261, 250, 59 + H_TOTAL);
        check("wrap_ones_l0", 16'(ones_line[0]), 16'($countones(rom[0])));

        // Off-screen sprite at y=255: fetches happen, nothing visible, no wrap to line 0
        do_reset();
        sprite_y = 9'd255;
        run(253, 250, 59 + 9 * H_TOTAL);
        check("offscreen_active_l253", 16'(line_seen[253]), 16'd0);
        for (int v = 254; v <= 261; v++)
            check($sformatf("offscreen_active_l%0d", v), 16'(line_seen[v]), 16'd1);
        check("offscreen_active_l0", 16'(line_seen[0]), 16'd0);

        // Mid-flight sprite_x change does not affect the already fetched row
        do_reset();
        sprite_x = 9'd100;
        sprite_y = 9'd50;
        run(59, 250, 109);
        sprite_x = 9'd20;
        run(60, 50, 259 + H_TOTAL);
        check("midflight_ones_l60", 16'(ones_line[60]), 16'($countones(rom[10])));
        check("midflight_ones_l61", 16'(ones_line[61]), 16'($countones(rom[11])));

        // Asynchronous reset in the middle of drawing line 55
        do_reset();
        sprite_x = 9'd100;
        run(54, 250, 165);
        check("pre_reset_active", 16'(active), 16'd1);
        check("pre_reset_pixel", 16'(pixel), 16'(rom[5][SPR_W-1-5]));
        reset = 1'b0;
        pend_valid = 0;
        #1;
        check("async_reset_pixel", 16'(pixel), 16'd0);
        check("async_reset_active", 16'(active), 16'd0);
        check("async_reset_rom_addr", 16'(rom_addr), 16'd0);
        run(55, 106, 14);
        reset = 1'b1;
        run(55, 120, (H_TOTAL - 120) + 2 * H_TOTAL);
        check("post_reset_ones_l55", 16'(ones_line[55]), 16'($countones(rom[5][SPR_W-1:SPR_W-6])));
        check("post_reset_ones_l56", 16'(ones_line[56]), 16'($countones(rom[6])));
        check("post_reset_ones_l57", 16'(ones_line[57]), 16'($countones(rom[7])));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
